// File: rtl/dm_param_sync.sv
// dm_param_sync: parametrised synchronous data memory with a valid/ready
// request port, a registered one-cycle response and an out-of-range error flag.
// After every reset an init engine rewrites the whole array with a known
// pattern: word i holds i (truncated to DATA_W) for i < INIT_COUNT, else 0.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RST        asynchronous active-high reset; restarts the init engine
//   req_valid  request present
//   req_ready  request can be accepted this cycle (high only once init is done)
//   req_we     1 = write, 0 = read
//   req_addr   word address, compared against DEPTH at full width
//   req_wdata  write data
//   rsp_valid  one-cycle pulse for the request accepted on the previous edge
//   rsp_data   read data; 0 for writes and errors; holds when no response
//   rsp_err    qualifies rsp_valid; set when req_addr >= DEPTH
//   init_busy  init engine running
module dm_param_sync #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned INIT_COUNT = 50
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q,     state_d;
    logic [IDX_W-1:0]    init_cnt_q,  init_cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                init_busy_q, init_busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                accept;
    logic                in_range;
    logic [IDX_W-1:0]    req_idx;
    logic [DATA_W-1:0]   init_val;

    // Request decode; the extra top bit keeps the range compare free of wrap-around
    always_comb begin
        accept   = req_valid && req_ready_q;
        in_range = ({1'b0, req_addr} < DEPTH_EXT);
        req_idx  = req_addr[IDX_W-1:0];
    end

    // Init pattern for the word currently addressed by the init engine
    always_comb begin
        init_val = '0;
        if (32'(init_cnt_q) < INIT_COUNT) begin
            init_val = DATA_W'(init_cnt_q);
        end
    end

    // Next-state, memory write port and response generation
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        mem_we      = 1'b0;
        mem_waddr   = init_cnt_q;
        mem_wdata   = init_val;

        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == LAST_IDX) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    if (!in_range) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end else if (req_we) begin
                        mem_we     = 1'b1;
                        mem_waddr  = req_idx;
                        mem_wdata  = req_wdata;
                        rsp_data_d = '0;
                    end else begin
                        rsp_data_d = mem[req_idx];
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        req_ready_d = (state_d == ST_RUN);
        init_busy_d = (state_d == ST_INIT);
    end

    // Control and response registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            req_ready_q <= 1'b0;
            init_busy_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            req_ready_q <= req_ready_d;
            init_busy_q <= init_busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Storage array; contents are restored by the init engine, not by reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign req_ready = req_ready_q;
    assign init_busy = init_busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dm_param_sync.sv
// Bench for dm_param_sync: two instances (DEPTH 256 and DEPTH 200) share one
// request stream; each is checked every cycle against its own behavioural model.
module tb_dm_param_sync;

    localparam int NI = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_we = 1'b0;
    logic [7:0]      req_addr = 8'h00;
    logic [7:0]      req_wdata = 8'h00;

    logic [NI-1:0]   rdy, busy, rv, re;
    logic [7:0]      rd [NI];

    dm_param_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_COUNT(50)) dut_a (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_data(rd[0]), .rsp_err(re[0]), .init_busy(busy[0])
    );

    dm_param_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .INIT_COUNT(50)) dut_b (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_data(rd[1]), .rsp_err(re[1]), .init_busy(busy[1])
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input int i);
        return (i == 0) ? 256 : 200;
    endfunction

    // Behavioural model: memory image, remaining init cycles, expected response
    logic [7:0] m_mem [NI][256];
    int         m_busy [NI];
    logic       m_v [NI];
    logic       m_e [NI];
    logic [7:0] m_d [NI];

    initial forever begin
        @(posedge CLK or posedge RST);
        for (int i = 0; i < NI; i++) begin
            if (RST) begin
                for (int a = 0; a < 256; a++) m_mem[i][a] = (a < 50) ? 8'(a) : 8'h00;
                m_busy[i] = depth_of(i);
                m_v[i] = 1'b0; m_e[i] = 1'b0; m_d[i] = 8'h00;
            end else if (m_busy[i] > 0) begin
                m_busy[i] = m_busy[i] - 1;
                m_v[i] = 1'b0; m_e[i] = 1'b0;
            end else if (req_valid) begin
                m_v[i] = 1'b1;
                if (int'(req_addr) >= depth_of(i)) begin
                    m_e[i] = 1'b1; m_d[i] = 8'h00;
                end else if (req_we) begin
                    m_e[i] = 1'b0; m_d[i] = 8'h00;
                    m_mem[i][req_addr] = req_wdata;
                end else begin
                    m_e[i] = 1'b0; m_d[i] = m_mem[i][req_addr];
                end
            end else begin
                m_v[i] = 1'b0; m_e[i] = 1'b0;
            end
        end
    end

    // Every-cycle comparison, well away from both clock edges
    initial forever begin
        @(negedge CLK);
        #2;
        for (int i = 0; i < NI; i++) begin
            chk("req_ready", i, 32'(rdy[i]),  32'(m_busy[i] == 0));
            chk("init_busy", i, 32'(busy[i]), 32'(m_busy[i] > 0));
            chk("rsp_valid", i, 32'(rv[i]),   32'(m_v[i]));
            chk("rsp_err",   i, 32'(re[i]),   32'(m_e[i]));
            chk("rsp_data",  i, 32'(rd[i]),   32'(m_d[i]));
        end
    end

    // Response captured at the negedge before the next request is driven
    logic [NI-1:0] cv, ce;
    logic [7:0]    cd [NI];

    task automatic step(input bit v, input bit we, input logic [7:0] a, input logic [7:0] wd);
        @(negedge CLK);
        for (int i = 0; i < NI; i++) begin
            cv[i] = rv[i]; ce[i] = re[i]; cd[i] = rd[i];
        end
        req_valid = v; req_we = we; req_addr = a; req_wdata = wd;
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (!(rdy[0] && rdy[1]) && w < 400) begin
            @(negedge CLK);
            w++;
        end
        chk(name, 0, 32'(rdy[0] && rdy[1]), 32'd1);
    endtask

    initial begin
        int  cnt;
        int  cnt_b;
        bit  seen_rsp;
        bit  done;
        logic [7:0] edge_addrs [6];

        edge_addrs = '{8'd0, 8'd49, 8'd50, 8'd199, 8'd200, 8'd255};

        #1 RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Init length, with a write to address 5 held valid throughout
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd5; req_wdata = 8'hEE;
        RST = 1'b0;
        cnt = 0; cnt_b = 0; seen_rsp = 1'b0; done = 1'b0;
        while (!done && cnt < 400) begin
            @(posedge CLK);
            #1;
            cnt++;
            if (rv[0]) seen_rsp = 1'b1;
            if (cnt_b == 0 && !busy[1]) cnt_b = cnt;
            if (!busy[0]) done = 1'b1;
        end
        req_valid = 1'b0;
        chk("t1_init_cycles", 0, 32'(cnt), 32'd256);
        chk("t1_init_cycles", 1, 32'(cnt_b), 32'd200);
        chk("t6_no_rsp_during_init", 0, 32'(seen_rsp), 32'd0);
        chk("t1_ready_after_init", 0, 32'(rdy[0]), 32'd1);

        // Init pattern reads, then back-to-back latency
        step(1, 0, 8'd0,   8'h00);
        step(1, 0, 8'd49,  8'h00); chk("t1_rd0",   0, 32'({cv[0], cd[0]}), 32'({1'b1, 8'd0}));
        step(1, 0, 8'd50,  8'h00); chk("t1_rd49",  0, 32'({cv[0], cd[0]}), 32'({1'b1, 8'd49}));
        step(1, 0, 8'd255, 8'h00); chk("t1_rd50",  0, 32'({cv[0], cd[0]}), 32'({1'b1, 8'd0}));
        step(1, 0, 8'd5,   8'h00); chk("t1_rd255", 0, 32'({cv[0], cd[0]}), 32'({1'b1, 8'd0}));
        step(1, 0, 8'd10,  8'h00); chk("t6_rd5",   0, 32'({cv[0], cd[0]}), 32'({1'b1, 8'd5}));
        step(1, 0, 8'd11,  8'h00);
        chk("t2_rd10", 0, 32'({cv[0], cd[0]}), 32'({1'b1, 8'd10}));
        step(1, 0, 8'd12,  8'h00); chk("t2_rd11",  0, 32'({cv[0], cd[0]}), 32'({1'b1, 8'd11}));
        step(0, 0, 8'd0,   8'h00); chk("t2_rd12",  0, 32'({cv[0], cd[0]}), 32'({1'b1, 8'd12}));
        step(0, 0, 8'd0,   8'h00); chk("t2_idle",  0, 32'({cv[0], cd[0]}), 32'({1'b0, 8'd12}));

        // Read-after-write
        step(1, 1, 8'd7, 8'hA5);
        step(1, 0, 8'd7, 8'h00); chk("t3_wr_rsp", 0, 32'({cv[0], ce[0], cd[0]}), 32'({1'b1, 1'b0, 8'h00}));
        step(0, 0, 8'd0, 8'h00); chk("t3_raw",    0, 32'({cv[0], ce[0], cd[0]}), 32'({1'b1, 1'b0, 8'hA5}));

        // Range boundary on the DEPTH=200 instance
        step(1, 1, 8'd220, 8'h3C);
        step(1, 0, 8'd220, 8'h00); chk("t4_wr_oor", 1, 32'({cv[1], ce[1], cd[1]}), 32'({1'b1, 1'b1, 8'h00}));
        step(1, 0, 8'd199, 8'h00); chk("t4_rd_oor", 1, 32'({cv[1], ce[1], cd[1]}), 32'({1'b1, 1'b1, 8'h00}));
        chk("t4_rd220_in_range", 0, 32'({cv[0], ce[0], cd[0]}), 32'({1'b1, 1'b0, 8'h3C}));
        step(0, 0, 8'd0, 8'h00);   chk("t4_rd199",  1, 32'({cv[1], ce[1], cd[1]}), 32'({1'b1, 1'b0, 8'h00}));

        // Reset while a read response is showing
        step(1, 1, 8'd3, 8'hFF);
        step(1, 0, 8'd3, 8'h00);
        @(negedge CLK);
        chk("t5_inflight", 0, 32'(rv[0]), 32'd1);
        RST = 1'b1; req_valid = 1'b0;
        #1;
        chk("t5_rst_drops_valid", 0, 32'(rv[0]), 32'd0);
        chk("t5_rst_busy", 0, 32'({rdy[0], busy[0]}), 32'({1'b0, 1'b1}));
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        wait_ready("t5_reinit_done");
        step(1, 0, 8'd3, 8'h00);
        step(0, 0, 8'd0, 8'h00); chk("t5_rd3", 0, 32'({cv[0], cd[0]}), 32'({1'b1, 8'h03}));

        // Randomised traffic with occasional resets; requests during init are ignored
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if ($urandom_range(0, 399) == 0) begin
                RST = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge CLK);
                RST = 1'b0;
            end
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) req_addr = edge_addrs[$urandom_range(0, 5)];
            else                           req_addr = 8'($urandom_range(0, 255));
            req_wdata = 8'($urandom_range(0, 255));
        end

        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
